// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and sizing helpers for the serial bit path
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SERDES_DEFAULT_WIDTH = 8;

  // Bits needed to hold an index 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle
interface piso_serializer_if
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_DEFAULT_WIDTH
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             sdata;
  logic             sframe;
  logic             done;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, sdata, sframe, done
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, sdata, sframe, done
  );
endinterface

// File: rtl/piso_serializer_bit_down_counter.sv
// rtl/piso_serializer_bit_down_counter.sv - loadable down counter with zero flag
module bit_down_counter
  import serdes_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] r_count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);
endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with framing strobe
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = SERDES_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               clr,
  piso_serializer_if.slave  bus
);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_sdata;
  logic             r_sframe;
  logic             r_done;

  logic w_zero;
  logic w_ready;
  logic w_accept;
  logic w_step;
  logic w_first_bit;
  logic w_next_bit;

  // Ready in idle, or in the last-bit slot so a new word can follow with no gap.
  assign w_ready  = (r_state == IDLE) ||
                    ((r_state == SHIFT) && w_zero && bus.shift_en);
  assign w_accept = bus.load_valid && w_ready;
  assign w_step   = (r_state == SHIFT) && bus.shift_en && !w_zero;

  // The output end of the register is always the bit currently on sdata.
  assign w_first_bit = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
  assign w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2]       : r_shreg[1];

  bit_down_counter #(
    .W (CW)
  ) u_bit_cnt (
    .clk        (clk),
    .clr        (clr),
    .load       (w_accept),
    .load_value (LAST_IDX),
    .en         (w_step),
    .zero       (w_zero)
  );

  // Transmit FSM: captures words, walks bits out, frames them and flags completion.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_sdata  <= 1'b0;
      r_sframe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg  <= bus.load_data;
            r_sdata  <= w_first_bit;
            r_sframe <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            if (!w_zero) begin
              r_shreg <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
              r_sdata <= w_next_bit;
            end else begin
              r_done <= 1'b1;
              if (w_accept) begin
                r_shreg <= bus.load_data;
                r_sdata <= w_first_bit;
              end else begin
                r_state  <= IDLE;
                r_sframe <= 1'b0;
                r_sdata  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.sdata      = r_sdata;
  assign bus.sframe     = r_sframe;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;
  logic clk = 1'b0;
  logic clr = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int ndone;
  logic [7:0] exp;

  piso_serializer_if #(.WIDTH(8)) m_if ();
  piso_serializer_if #(.WIDTH(8)) l_if ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .clr (clr),
    .bus (m_if)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .clr (clr),
    .bus (l_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_if.load_valid = 1'b0; m_if.load_data = 8'h00; m_if.shift_en = 1'b0;
    l_if.load_valid = 1'b0; l_if.load_data = 8'h00; l_if.shift_en = 1'b0;

    // Reset held with clock running
    repeat (3) tick();
    chk("rst_m_sdata",  m_if.sdata, 0);
    chk("rst_m_sframe", m_if.sframe, 0);
    chk("rst_m_done",   m_if.done, 0);
    chk("rst_m_ready",  m_if.load_ready, 1);
    chk("rst_l_sframe", l_if.sframe, 0);
    chk("rst_l_ready",  l_if.load_ready, 1);
    clr = 1'b1;
    tick();

    // Asynchronous clear mid-word, no clock edge in between
    m_if.load_valid = 1'b1; m_if.load_data = 8'hA5; m_if.shift_en = 1'b1;
    tick();
    m_if.load_valid = 1'b0;
    chk("async_pre_sframe", m_if.sframe, 1);
    chk("async_pre_sdata",  m_if.sdata, 1);
    #2 clr = 1'b0;
    #1;
    chk("async_sframe", m_if.sframe, 0);
    chk("async_sdata",  m_if.sdata, 0);
    chk("async_ready",  m_if.load_ready, 1);
    tick();
    clr = 1'b1;
    tick();

    // MSB-first 8'hA5 with continuous enable
    m_if.load_valid = 1'b1; m_if.load_data = 8'hA5; m_if.shift_en = 1'b1;
    tick();
    m_if.load_valid = 1'b0; m_if.load_data = 8'h00;
    exp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("msb_sdata",  m_if.sdata, exp[7-i]);
      chk("msb_sframe", m_if.sframe, 1);
      chk("msb_done",   m_if.done, 0);
      chk("msb_ready",  m_if.load_ready, 32'(i == 7));
      tick();
    end
    chk("msb_done_pulse",  m_if.done, 1);
    chk("msb_sframe_end",  m_if.sframe, 0);
    chk("msb_sdata_end",   m_if.sdata, 0);
    tick();
    chk("msb_done_clear",  m_if.done, 0);
    m_if.shift_en = 1'b0;

    // LSB-first 8'h3C, enable every 4th cycle
    l_if.load_valid = 1'b1; l_if.load_data = 8'h3C; l_if.shift_en = 1'b0;
    tick();
    l_if.load_valid = 1'b0;
    exp = 8'h3C;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        l_if.shift_en = (j == 3);
        #1;
        chk("lsb_sdata",  l_if.sdata, exp[i]);
        chk("lsb_sframe", l_if.sframe, 1);
        chk("lsb_ready",  l_if.load_ready, 32'((i == 7) && (j == 3)));
        ndone += int'(l_if.done);
        tick();
      end
    end
    l_if.shift_en = 1'b0;
    chk("lsb_done_pulse", l_if.done, 1);
    chk("lsb_sframe_end", l_if.sframe, 0);
    ndone += int'(l_if.done);
    tick();
    ndone += int'(l_if.done);
    chk("lsb_done_count", ndone, 1);

    // Back-to-back 8'hFF then 8'h00
    m_if.load_valid = 1'b1; m_if.load_data = 8'hFF; m_if.shift_en = 1'b1;
    tick();
    m_if.load_data = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) m_if.load_valid = 1'b0;
      #1;
      chk("b2b_sdata",  m_if.sdata, 32'(c <= 8));
      chk("b2b_sframe", m_if.sframe, 1);
      chk("b2b_done",   m_if.done, 32'(c == 9));
      chk("b2b_ready",  m_if.load_ready, 32'((c == 8) || (c == 16)));
      tick();
    end
    chk("b2b_done17",   m_if.done, 1);
    chk("b2b_sframe17", m_if.sframe, 0);
    tick();
    chk("b2b_done18",   m_if.done, 0);

    // Abort 8'h81 after three bits, then resend
    m_if.load_valid = 1'b1; m_if.load_data = 8'h81;
    tick();
    m_if.load_valid = 1'b0;
    exp = 8'h81;
    for (int i = 0; i < 3; i++) begin
      chk("abort_pre_sdata", m_if.sdata, exp[7-i]);
      tick();
    end
    clr = 1'b0;
    #1;
    chk("abort_sframe", m_if.sframe, 0);
    chk("abort_done",   m_if.done, 0);
    chk("abort_ready",  m_if.load_ready, 1);
    tick();
    chk("abort_done_a", m_if.done, 0);
    tick();
    chk("abort_done_b", m_if.done, 0);
    clr = 1'b1;
    tick();
    chk("abort_idle_sframe", m_if.sframe, 0);
    m_if.load_valid = 1'b1; m_if.load_data = 8'h81;
    tick();
    m_if.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("resend_sdata",  m_if.sdata, exp[7-i]);
      chk("resend_sframe", m_if.sframe, 1);
      tick();
    end
    chk("resend_done", m_if.done, 1);
    m_if.shift_en = 1'b0;
    tick();

    // Backpressure: new data offered mid-word must be ignored
    l_if.load_valid = 1'b1; l_if.load_data = 8'h5A; l_if.shift_en = 1'b1;
    tick();
    l_if.load_data = 8'hC3;
    exp = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) l_if.load_valid = 1'b0;
      #1;
      chk("bp_sdata", l_if.sdata, exp[c]);
      chk("bp_ready", l_if.load_ready, 32'(c == 7));
      tick();
    end
    chk("bp_done",   l_if.done, 1);
    chk("bp_sframe", l_if.sframe, 0);
    tick();
    chk("bp_no_reload", l_if.sframe, 0);
    chk("bp_done_clr",  l_if.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
